// File: rtl/mandelbrot_pixel_streamer_if.sv
// Pixel stream bundle: the RGB555 readback side feeding the streamer and the
// RGB888 valid/ready beat stream with start-of-frame and end-of-line markers.
interface mandelbrot_pixel_streamer_if #(
    parameter int CW = 10
);
    logic          in_valid;
    logic          in_ready;
    logic [14:0]   in_rgb;
    logic [CW-1:0] in_x;
    logic [CW-1:0] in_y;
    logic [23:0]   out_tdata;
    logic          out_tvalid;
    logic          out_tready;
    logic          out_tuser;
    logic          out_tlast;

    modport master (
        output in_valid, in_rgb, in_x, in_y, out_tready,
        input  in_ready, out_tdata, out_tvalid, out_tuser, out_tlast
    );

    modport slave (
        input  in_valid, in_rgb, in_x, in_y, out_tready,
        output in_ready, out_tdata, out_tvalid, out_tuser, out_tlast
    );
endinterface

// File: rtl/mandelbrot_pixel_streamer.sv
// Buffers Mandelbrot readback pixels, expands RGB555 to RGB888, tags frame/line
// markers and checks raster order of the incoming coordinates.
module mandelbrot_pixel_streamer #(
    parameter int DEPTH = 16,
    parameter int CW    = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [CW-1:0]                    x_size,
    input  logic [CW-1:0]                    y_size,
    mandelbrot_pixel_streamer_if.slave       pix,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             seq_err,
    output logic                             cfg_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 26;
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CRD_ONE  = CW'(1);
    localparam logic [CW-1:0] CRD_ZERO = CW'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    function automatic logic [7:0] expand5(input logic [4:0] c5);
        return {c5, c5[4:2]};
    endfunction

    state_t          state_r, state_s;
    logic [CW-1:0]   xs_r, ys_r, ex_r, ey_r;
    logic [CW-1:0]   ex_s, ey_s, xs_m1_s, ys_m1_s;
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [AW:0]     count_r, count_s;
    logic [EW-1:0]   mem_r [DEPTH];
    logic [EW-1:0]   wr_entry_s, head_s;
    logic            push_s, pop_s, wrap_s, last_pos_s, mismatch_s, sof_s, eol_s;
    logic            start_ok_s, start_bad_s, final_pop_s;
    logic            in_ready_r, out_tvalid_r, busy_r, frame_done_r, seq_err_r, cfg_err_r;

    assign xs_m1_s = xs_r - CRD_ONE;
    assign ys_m1_s = ys_r - CRD_ONE;
    assign head_s  = mem_r[rd_ptr_r];

    // Push-side position tracking, entry formatting and occupancy arithmetic.
    always_comb begin
        push_s     = pix.in_valid && in_ready_r;
        pop_s      = out_tvalid_r && pix.out_tready;
        mismatch_s = (pix.in_x != ex_r) || (pix.in_y != ey_r);
        // Tag and advance from the received coordinate, which is the resync point on error.
        wrap_s     = (pix.in_x >= xs_m1_s);
        last_pos_s = wrap_s && (pix.in_y >= ys_m1_s);
        eol_s      = (pix.in_x == xs_m1_s);
        sof_s      = (pix.in_x == CRD_ZERO) && (pix.in_y == CRD_ZERO);
        if (wrap_s) begin
            ex_s = CRD_ZERO;
            ey_s = pix.in_y + CRD_ONE;
        end else begin
            ex_s = pix.in_x + CRD_ONE;
            ey_s = pix.in_y;
        end
        wr_entry_s = {expand5(pix.in_rgb[14:10]), expand5(pix.in_rgb[9:5]),
                      expand5(pix.in_rgb[4:0]), sof_s, eol_s};
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // Frame sequencing: arm on start, collect until the last position, drain to empty.
    always_comb begin
        state_s     = state_r;
        start_ok_s  = 1'b0;
        start_bad_s = 1'b0;
        final_pop_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (x_size != CRD_ZERO) && (y_size != CRD_ZERO)) begin
                    state_s    = ACTIVE;
                    start_ok_s = 1'b1;
                end else if (start) begin
                    start_bad_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (push_s && last_pos_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ACTIVE;
                end
            end
            DRAIN: begin
                if (pop_s && (count_r == CNT_ONE)) begin
                    state_s     = IDLE;
                    final_pop_s = 1'b1;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Control state, pointers, registered handshake outputs and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            xs_r         <= CRD_ZERO;
            ys_r         <= CRD_ZERO;
            ex_r         <= CRD_ZERO;
            ey_r         <= CRD_ZERO;
            wr_ptr_r     <= AW'(0);
            rd_ptr_r     <= AW'(0);
            count_r      <= CNT_ZERO;
            in_ready_r   <= 1'b0;
            out_tvalid_r <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            seq_err_r    <= 1'b0;
            cfg_err_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start_ok_s) begin
                xs_r <= x_size;
                ys_r <= y_size;
                ex_r <= CRD_ZERO;
                ey_r <= CRD_ZERO;
            end else if (push_s) begin
                ex_r <= ex_s;
                ey_r <= ey_s;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r      <= count_s;
            in_ready_r   <= (state_s == ACTIVE) && (count_s < DEPTH_C);
            out_tvalid_r <= (count_s != CNT_ZERO);
            busy_r       <= (state_s != IDLE);
            frame_done_r <= final_pop_s;
            if (start_ok_s) begin
                seq_err_r <= 1'b0;
            end else if (push_s && mismatch_s) begin
                seq_err_r <= 1'b1;
            end
            if (start_bad_s) begin
                cfg_err_r <= 1'b1;
            end
        end
    end

    // Pixel storage; contents are don't-care until written, pointers carry the reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    assign pix.in_ready   = in_ready_r;
    assign pix.out_tvalid = out_tvalid_r;
    assign pix.out_tdata  = head_s[25:2];
    assign pix.out_tuser  = head_s[1];
    assign pix.out_tlast  = head_s[0];
    assign busy           = busy_r;
    assign frame_done     = frame_done_r;
    assign seq_err        = seq_err_r;
    assign cfg_err        = cfg_err_r;
endmodule

// File: tb/tb_mandelbrot_pixel_streamer.sv
// Scoreboard bench: the driver queues the expected beat for every accepted pixel,
// an independent monitor pops and compares each transferred beat.
module tb_mandelbrot_pixel_streamer;
    localparam int DEPTH = 16;
    localparam int CW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] x_size = '0;
    logic [CW-1:0] y_size = '0;
    logic          busy, frame_done, seq_err, cfg_err;

    mandelbrot_pixel_streamer_if #(.CW(CW)) pix();

    mandelbrot_pixel_streamer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .x_size(x_size), .y_size(y_size),
        .pix(pix), .busy(busy), .frame_done(frame_done), .seq_err(seq_err), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          frame_done_cnt = 0;
    int          beat_cnt = 0;
    int          cur_xs = 1;
    logic [25:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input logic [14:0] c);
        return {c[14:10], c[14:12], c[9:5], c[9:7], c[4:0], c[4:2]};
    endfunction

    // Monitor: compares every transferred beat, stall stability and frame_done timing.
    initial begin
        logic        prev_xfer;
        logic        prev_stall;
        logic [25:0] held_beat;
        logic [25:0] beat;
        logic [25:0] want;
        prev_xfer  = 1'b0;
        prev_stall = 1'b0;
        held_beat  = '0;
        forever begin
            @(negedge clk);
            beat = {pix.out_tdata, pix.out_tuser, pix.out_tlast};
            if (rst) begin
                if (frame_done) begin
                    frame_done_cnt++;
                    chk("frame_done_after_last_beat", {31'd0, prev_xfer && (exp_q.size() == 0)}, 32'd1);
                end
                if (prev_stall) begin
                    chk("stall_hold", {5'd0, pix.out_tvalid, beat}, {5'd0, 1'b1, held_beat});
                end
                if (exp_q.size() == DEPTH) begin
                    chk("full_blocks_input", {31'd0, pix.in_ready}, 32'd0);
                end
                if (pix.out_tvalid && pix.out_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {6'd0, beat}, 32'hFFFF_FFFF);
                    end else begin
                        want = exp_q.pop_front();
                        chk("beat", {6'd0, beat}, {6'd0, want});
                        beat_cnt++;
                    end
                    prev_xfer = 1'b1;
                end else begin
                    prev_xfer = 1'b0;
                end
                prev_stall = pix.out_tvalid && !pix.out_tready;
                held_beat  = beat;
            end else begin
                prev_xfer  = 1'b0;
                prev_stall = 1'b0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int xs, input int ys);
        start  = 1'b1;
        x_size = CW'(xs);
        y_size = CW'(ys);
        if (xs != 0 && ys != 0) cur_xs = xs;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic send_pix(input logic [14:0] rgb, input int x, input int y, input logic [23:0] exp_data);
        int   t = 0;
        logic accepted = 1'b0;
        pix.in_valid = 1'b1;
        pix.in_rgb   = rgb;
        pix.in_x     = CW'(x);
        pix.in_y     = CW'(y);
        while (!accepted && t < 500) begin
            @(negedge clk);
            if (pix.in_ready) begin
                accepted = 1'b1;
                exp_q.push_back({exp_data, (x == 0 && y == 0), (x == cur_xs - 1)});
            end
            @(posedge clk);
            #1;
            t++;
        end
        pix.in_valid = 1'b0;
        if (!accepted) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 2000) begin
            cycles(1);
            t++;
        end
        if (t >= 2000) chk("drain_timeout", 32'd0, 32'd1);
        cycles(1);
    endtask

    task automatic send_pattern(input int x, input int y);
        logic [14:0] rgb;
        rgb = {5'(x * 7 + 1), 5'(y * 9 + 3), 5'(x + y * 4)};
        send_pix(rgb, x, y, exp_rgb(rgb));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        pix.in_valid   = 1'b0;
        pix.in_rgb     = '0;
        pix.in_x       = '0;
        pix.in_y       = '0;
        pix.out_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",   {31'd0, pix.in_ready},   32'd0);
        chk("rst_out_tvalid", {31'd0, pix.out_tvalid}, 32'd0);
        chk("rst_busy",       {31'd0, busy},           32'd0);
        chk("rst_frame_done", {31'd0, frame_done},     32'd0);
        chk("rst_seq_err",    {31'd0, seq_err},        32'd0);
        chk("rst_cfg_err",    {31'd0, cfg_err},        32'd0);
        rst = 1'b1;
        cycles(2);

        // Clean 4x2 frame
        pix.out_tready = 1'b1;
        start_frame(4, 2);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                send_pattern(x, y);
        wait_idle();
        chk("clean_frame_done_cnt", frame_done_cnt, 32'd1);
        chk("clean_beats", beat_cnt, 32'd8);
        chk("clean_seq_err", {31'd0, seq_err}, 32'd0);

        // Colour expansion corners
        start_frame(3, 1);
        send_pix(15'h7FFF, 0, 0, 24'hFFFFFF);
        chk("latency_one_cycle", {31'd0, pix.out_tvalid}, 32'd1);
        send_pix(15'h0000, 1, 0, 24'h000000);
        send_pix(15'h4210, 2, 0, 24'h848484);
        wait_idle();
        chk("colour_frame_done_cnt", frame_done_cnt, 32'd2);

        // Backpressure: fill, then drain with intermittent ready while refilling
        pix.out_tready = 1'b0;
        start_frame(32, 1);
        for (int i = 0; i < 16; i++) send_pattern(i, 0);
        cycles(2);
        chk("full_in_ready", {31'd0, pix.in_ready},   32'd0);
        chk("full_tvalid",   {31'd0, pix.out_tvalid}, 32'd1);
        fork
            begin
                for (int i = 16; i < 32; i++) send_pattern(i, 0);
            end
            begin
                int t = 0;
                while ((exp_q.size() != 0 || busy) && t < 1000) begin
                    pix.out_tready = ((t % 3) != 0);
                    cycles(1);
                    t++;
                end
                pix.out_tready = 1'b1;
            end
        join
        wait_idle();
        chk("bp_frame_done_cnt", frame_done_cnt, 32'd3);
        chk("bp_beats", beat_cnt, 32'd43);

        // Order error: x = 0, 2, 3
        start_frame(4, 1);
        send_pix(15'h0421, 0, 0, 24'h080808);
        chk("order_seq_err_first", {31'd0, seq_err}, 32'd0);
        send_pix(15'h7C00, 2, 0, 24'hFF0000);
        chk("order_seq_err_second", {31'd0, seq_err}, 32'd1);
        send_pix(15'h001F, 3, 0, 24'h0000FF);
        wait_idle();
        chk("order_frame_done_cnt", frame_done_cnt, 32'd4);
        chk("order_beats", beat_cnt, 32'd46);

        // Zero size configuration
        start_frame(4, 0);
        chk("cfg_err_set", {31'd0, cfg_err}, 32'd1);
        chk("cfg_busy", {31'd0, busy}, 32'd0);
        chk("cfg_seq_err_kept", {31'd0, seq_err}, 32'd1);

        // Reset with pixels buffered
        pix.out_tready = 1'b0;
        start_frame(8, 1);
        chk("start_clears_seq_err", {31'd0, seq_err}, 32'd0);
        for (int i = 0; i < 5; i++) send_pattern(i, 0);
        chk("pre_rst_tvalid", {31'd0, pix.out_tvalid}, 32'd1);
        fd0 = frame_done_cnt;
        rst = 1'b0;
        #1;
        chk("mid_rst_tvalid", {31'd0, pix.out_tvalid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        cycles(2);
        chk("mid_rst_cfg_err_clear", {31'd0, cfg_err}, 32'd0);
        rst = 1'b1;
        cycles(3);
        chk("mid_rst_no_frame_done", frame_done_cnt, fd0);
        pix.out_tready = 1'b1;
        start_frame(2, 2);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 2; x++)
                send_pattern(x, y);
        wait_idle();
        chk("post_rst_frame_done_cnt", frame_done_cnt, fd0 + 1);
        chk("post_rst_beats", beat_cnt, 32'd50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
